// File: rtl/ah_decode_pkg.sv
// Shared widths, range-table entry type and FSM states for the address-range decode scheduler.
package ah_decode_pkg;

  localparam int unsigned FIELD_W      = 96;
  localparam int unsigned NUM_CLIENTS  = 15;
  localparam int unsigned CLIENT_IDX_W = 4;
  localparam logic [CLIENT_IDX_W-1:0] NO_CLIENT = 4'hF;

  typedef struct packed {
    logic               valid;
    logic [FIELD_W-1:0] bom;
    logic [FIELD_W-1:0] tom;
  } range_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } state_e;

  // Inclusive unsigned range test; bom > tom can never satisfy both bounds.
  function automatic logic entry_hit(input range_entry_t e, input logic [FIELD_W-1:0] f);
    return e.valid && (f >= e.bom) && (f <= e.tom);
  endfunction

endpackage

// File: rtl/ah_decode_range_table.sv
// Programmable client range table with a parallel compare and lowest-index priority encode.
module ah_decode_range_table
  import ah_decode_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [CLIENT_IDX_W-1:0] wr_idx,
  input  logic [FIELD_W-1:0]      wr_bom,
  input  logic [FIELD_W-1:0]      wr_tom,
  input  logic [FIELD_W-1:0]      lookup_field,
  output logic [CLIENT_IDX_W-1:0] hit_idx,
  output logic                    hit_err
);

  range_entry_t           entries [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] hits;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
        entries[i] <= '{valid: 1'b0, bom: '1, tom: '0};
      end
    end else if (wr_en && (32'(wr_idx) < NUM_CLIENTS)) begin
      entries[wr_idx] <= '{valid: 1'b1, bom: wr_bom, tom: wr_tom};
    end
  end

  always_comb begin
    hits = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      hits[i] = entry_hit(entries[i], lookup_field);
    end
  end

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit_idx = NO_CLIENT;
    for (int i = int'(NUM_CLIENTS) - 1; i >= 0; i--) begin
      if (hits[i]) begin
        hit_idx = CLIENT_IDX_W'(i);
      end
    end
  end

  assign hit_err = ~|hits;

endmodule

// File: rtl/ah_decode_scheduler.sv
// Round-robin arbiter sharing one range decoder among requesters, with a serialised config port.
module ah_decode_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned FIELD_W     = 96,
  parameter int unsigned NUM_CLIENTS = 15,
  parameter int unsigned REQ_ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*FIELD_W-1:0] req_field,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       cfg_wr_en,
  input  logic [3:0]                 cfg_client_idx,
  input  logic [FIELD_W-1:0]         cfg_bom,
  input  logic [FIELD_W-1:0]         cfg_tom,
  output logic                       cfg_busy,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [REQ_ID_W-1:0]        rsp_req_id,
  output logic [3:0]                 rsp_client_idx,
  output logic                       rsp_dec_err
);

  import ah_decode_pkg::*;

  state_e                state;
  logic [REQ_ID_W-1:0]   rr_ptr;
  logic [REQ_ID_W-1:0]   gnt_id;
  logic [REQ_ID_W-1:0]   cand;
  logic                  gnt_any;
  logic                  grant;
  logic                  cfg_accept;
  logic [FIELD_W-1:0]    field_q;
  logic [3:0]            hit_idx;
  logic                  hit_err;

  // Config write beats arbitration in IDLE; out-of-range writes neither land nor block a grant.
  always_comb begin
    cfg_accept = (state == IDLE) && cfg_wr_en && (32'(cfg_client_idx) < NUM_CLIENTS);
    gnt_any    = 1'b0;
    gnt_id     = '0;
    cand       = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      cand = REQ_ID_W'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
      if (req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
    grant     = (state == IDLE) && !cfg_accept && gnt_any;
    req_ready = '0;
    if (grant) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  assign cfg_busy = (state != IDLE);

  ah_decode_range_table u_table (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (cfg_accept),
    .wr_idx       (cfg_client_idx),
    .wr_bom       (cfg_bom),
    .wr_tom       (cfg_tom),
    .lookup_field (field_q),
    .hit_idx      (hit_idx),
    .hit_err      (hit_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      field_q        <= '0;
      rsp_valid      <= 1'b0;
      rsp_req_id     <= '0;
      rsp_client_idx <= NO_CLIENT;
      rsp_dec_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            field_q    <= req_field[32'(gnt_id)*FIELD_W +: FIELD_W];
            rsp_req_id <= gnt_id;
            rr_ptr     <= REQ_ID_W'((32'(gnt_id) + 32'd1) % NUM_REQ);
            state      <= LOOKUP;
          end
        end
        LOOKUP: begin
          rsp_client_idx <= hit_idx;
          rsp_dec_err    <= hit_err;
          rsp_valid      <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ah_decode_scheduler.sv
// Directed bench for ah_decode_scheduler; inputs change and outputs are sampled on the falling edge.
module tb_ah_decode_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned FW = 96;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*FW-1:0] req_field;
  logic [NR-1:0]    req_ready;
  logic             cfg_wr_en;
  logic [3:0]       cfg_client_idx;
  logic [FW-1:0]    cfg_bom;
  logic [FW-1:0]    cfg_tom;
  logic             cfg_busy;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_req_id;
  logic [3:0]       rsp_client_idx;
  logic             rsp_dec_err;

  int vectors     = 0;
  int miscompares = 0;

  ah_decode_scheduler #(
    .NUM_REQ(NR), .FIELD_W(FW), .NUM_CLIENTS(15), .REQ_ID_W(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_field      (req_field),
    .req_ready      (req_ready),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_client_idx (cfg_client_idx),
    .cfg_bom        (cfg_bom),
    .cfg_tom        (cfg_tom),
    .cfg_busy       (cfg_busy),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_req_id     (rsp_req_id),
    .rsp_client_idx (rsp_client_idx),
    .rsp_dec_err    (rsp_dec_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    cfg_wr_en = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [FW-1:0] bom, input logic [FW-1:0] tom);
    cfg_wr_en      = 1'b1;
    cfg_client_idx = idx;
    cfg_bom        = bom;
    cfg_tom        = tom;
    #1 chk("cfg_idle_busy", 32'(cfg_busy), 32'd0);
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  // Single-requester lookup with rsp_ready high: grant, LOOKUP, RESP, back to IDLE.
  task automatic lookup(input int id, input logic [FW-1:0] f, input logic [3:0] eidx,
                        input logic eerr, input string tag);
    req_valid              = '0;
    req_valid[id]          = 1'b1;
    req_field[id*FW +: FW] = f;
    #1 chk({tag, ":ready"}, 32'(req_ready), 32'd1 << id);
    @(negedge clk);
    req_valid = '0;
    chk({tag, ":busy"}, 32'(cfg_busy), 32'd1);
    chk({tag, ":early_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, ":valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ":idx"}, 32'(rsp_client_idx), 32'(eidx));
    chk({tag, ":err"}, 32'(rsp_dec_err), 32'(eerr));
    chk({tag, ":id"}, 32'(rsp_req_id), 32'(id));
    @(negedge clk);
    chk({tag, ":done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = '0;
    req_field      = '0;
    cfg_wr_en      = 1'b0;
    cfg_client_idx = '0;
    cfg_bom        = '0;
    cfg_tom        = '0;
    rsp_ready      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_idx", 32'(rsp_client_idx), 32'hF);
    chk("rst_err", 32'(rsp_dec_err), 32'd0);
    chk("rst_id", 32'(rsp_req_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    @(negedge clk);

    lookup(0, 96'h1000, 4'hF, 1'b1, "empty");

    cfg_write(4'd2, 96'h2000, 96'h2FFF);
    lookup(1, 96'h2000, 4'd2, 1'b0, "lo_bound");
    lookup(2, 96'h2FFF, 4'd2, 1'b0, "hi_bound");
    lookup(3, 96'h3000, 4'hF, 1'b1, "above");
    lookup(0, 96'h1FFF, 4'hF, 1'b1, "below");

    cfg_write(4'd4, 96'h5000, 96'h4000);
    lookup(1, 96'h4800, 4'hF, 1'b1, "inverted");

    cfg_write(4'd1, 96'h0, 96'hFFFF);
    cfg_write(4'd3, 96'h100, 96'h1FF);
    lookup(2, 96'h150, 4'd1, 1'b0, "overlap");

    cfg_write(4'd15, 96'h0, {FW{1'b1}});
    lookup(3, 96'h1_0000_0000, 4'hF, 1'b1, "dropped_wr");

    // Round robin with all requesters valid and rsp_ready high.
    do_reset();
    for (int i = 0; i < int'(NR); i++) req_field[i*FW +: FW] = 96'h42;
    req_valid = '1;
    for (int c = 0; c <= 12; c++) begin
      #1;
      chk("rr_ready", 32'(req_ready), (c % 3 == 0) ? (32'd1 << ((c / 3) % 4)) : 32'd0);
      if (c % 3 == 2) begin
        chk("rr_valid", 32'(rsp_valid), 32'd1);
        chk("rr_id", 32'(rsp_req_id), 32'((c / 3) % 4));
      end
      if (c == 12) req_valid = '0;
      @(negedge clk);
    end

    // Stalled response with a pending config write and a pending request.
    req_field[2*FW +: FW] = 96'h7800;
    req_field[0 +: FW]    = 96'h7800;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1 chk("stall_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid      = 4'b0001;
    cfg_wr_en      = 1'b1;
    cfg_client_idx = 4'd5;
    cfg_bom        = 96'h7000;
    cfg_tom        = 96'h7FFF;
    #1;
    chk("stall_busy_lookup", 32'(cfg_busy), 32'd1);
    chk("stall_ready_lookup", 32'(req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_busy", 32'(cfg_busy), 32'd1);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_id", 32'(rsp_req_id), 32'd2);
      chk("stall_idx", 32'(rsp_client_idx), 32'hF);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("cfgwin_busy", 32'(cfg_busy), 32'd0);
    chk("cfgwin_valid", 32'(rsp_valid), 32'd0);
    chk("cfgwin_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    cfg_wr_en = 1'b0;
    #1 chk("after_cfg_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("after_cfg_valid", 32'(rsp_valid), 32'd1);
    chk("after_cfg_idx", 32'(rsp_client_idx), 32'd5);
    chk("after_cfg_err", 32'(rsp_dec_err), 32'd0);
    chk("after_cfg_id", 32'(rsp_req_id), 32'd0);
    @(negedge clk);

    // Reset while a lookup is in flight.
    cfg_write(4'd0, 96'h0, 96'hFFFF);
    lookup(1, 96'h10, 4'd0, 1'b0, "pre_rst");
    req_field[3*FW +: FW] = 96'h10;
    req_valid = 4'b1000;
    #1 chk("inflight_grant", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(cfg_busy), 32'd0);
    chk("midrst_idx", 32'(rsp_client_idx), 32'hF);
    @(negedge clk);
    chk("midrst_valid2", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < int'(NR); i++) req_field[i*FW +: FW] = 96'h10;
    req_valid = '1;
    #1 chk("postrst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("postrst_valid", 32'(rsp_valid), 32'd1);
    chk("postrst_id", 32'(rsp_req_id), 32'd0);
    chk("postrst_err", 32'(rsp_dec_err), 32'd1);
    chk("postrst_idx", 32'(rsp_client_idx), 32'hF);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ah_decode_scheduler.md
# ah_decode_scheduler

Shares one programmable address-range decoder among several ingress requesters. A round-robin arbiter grants one requester at a time and looks up its 96-bit packet field in a 15-entry range table. It returns the matching client index, or a decode error, over a valid/ready response channel. The block also owns the runtime configuration port that programs each client's bottom/top range, and it serialises configuration writes against in-flight lookups.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- FIELD_W, 96, packet field width
- NUM_CLIENTS, 15, range-table entries
- REQ_ID_W, 2, clog2(NUM_REQ)

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester lookup request
- req_field  in  NUM_REQ*FIELD_W  requester i field at [i*FIELD_W +: FIELD_W]
- req_ready  out  NUM_REQ  one-hot accept pulse
- cfg_wr_en  in  1  range-table write strobe
- cfg_client_idx  in  4  entry to write
- cfg_bom  in  FIELD_W  range bottom, inclusive
- cfg_tom  in  FIELD_W  range top, inclusive
- cfg_busy  out  1  write not accepted this cycle
- rsp_valid  out  1  lookup result valid
- rsp_ready  in  1  consumer accepts result
- rsp_req_id  out  REQ_ID_W  granted requester
- rsp_client_idx  out  4  matching client, 4'hF when none
- rsp_dec_err  out  1  no entry matched

## Operation
- FSM states: IDLE, LOOKUP, RESP.
- IDLE:
  - If cfg_wr_en is high and cfg_client_idx < NUM_CLIENTS, write the entry (bom, tom, entry-valid=1). Config wins over arbitration that cycle; no grant is issued.
  - A write with cfg_client_idx ≥ NUM_CLIENTS is dropped silently.
  - Otherwise, if any req_valid is set, grant round-robin starting at rr_ptr. Pulse req_ready[g], capture req_field[g] and g, and go to LOOKUP.
  - After a grant, rr_ptr = g+1 mod NUM_REQ.
- LOOKUP: an entry hits when entry-valid and bom ≤ field ≤ tom (unsigned, full FIELD_W).
  - Multiple hits: the lowest index wins.
  - Register the index and err = ~|hits. Go to RESP.
- RESP: hold rsp_* stable and rsp_valid high until rsp_ready is high. Return to IDLE in the cycle after the handshake.
- cfg_busy = (state != IDLE). A write is accepted only when cfg_wr_en is high and cfg_busy is low. The writer holds cfg_wr_en and the data until acceptance.
- An entry with bom > tom never matches.
- Reset:
  - state = IDLE; rr_ptr = 0.
  - All entries: valid = 0, bom = all-ones, tom = 0.
  - rsp_valid = 0, rsp_client_idx = 4'hF, rsp_dec_err = 0, rsp_req_id = 0, req_ready = 0, cfg_busy = 0.

## Timing
- A grant in cycle T (req_ready pulse) gives rsp_valid in T+2 at the earliest.
- Minimum spacing between grants is 3 cycles (T, T+3) when rsp_ready is tied high.
- req_ready is combinational from req_valid/state/rr_ptr/cfg_wr_en and is high for exactly one cycle per grant.
- A requester must hold req_valid and req_field until it sees req_ready.
- A config write accepted in cycle T affects any lookup granted in T+1 or later. An in-flight lookup never sees a partial table.
- rst asserted in any state overrides everything on the next edge: the in-flight request is dropped and no response is produced.
- rsp_valid may stall indefinitely. The captured field is held, and no new grants or config writes occur until the handshake.

## Structure
- Package ah_decode_pkg:
  - FIELD_W, NUM_CLIENTS, CLIENT_IDX_W = 4, NO_CLIENT = 4'hF
  - range_entry_t struct {valid, bom, tom}
  - state enum {IDLE, LOOKUP, RESP}
- Sub-module ah_decode_range_table:
  - owns the entry registers, the write port, and the parallel compare plus lowest-index priority encode
  - outputs hit index and err combinationally
- The top level holds the arbiter, FSM and response registers.

## Test plan
- Reset, then lookup with no entries programmed: field 96'h1000 from req 0 → rsp_dec_err=1, rsp_client_idx=4'hF, rsp_req_id=0.
- Program entry 2 = [96'h2000, 96'h2FFF], then lookup 96'h2000, 96'h2FFF and 96'h3000 → hits on idx 2, idx 2, then error; both bounds are inclusive.
- Overlapping entries 1 = [0, 96'hFFFF] and 3 = [96'h100, 96'h1FF], lookup 96'h150 → idx 1 (lowest index wins).
- All 4 requesters valid continuously with rsp_ready=1 → grants in order 0,1,2,3,0 every 3 cycles, with rsp_req_id matching.
- cfg_wr_en held during RESP with rsp_ready=0 for 5 cycles → cfg_busy=1 throughout. The write lands in the IDLE cycle and beats a pending req_valid in that same cycle.
- rst pulsed in LOOKUP → no rsp_valid, the table is cleared, and the next grant goes to req 0.
